// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 32-bit SRAM bank between the
// instruction-fetch port (read only) and the load/store data port.
// Multi-cycle SRAM timing with RD_WAIT / WR_WAIT extra wait states.
// All SRAM pin outputs are registered; ready is a one-cycle pulse.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin priority pointer on
// simultaneous requests (default build: fixed data-over-instruction priority).
module sram_arbiter #(
    parameter int unsigned RD_WAIT = 0,
    parameter int unsigned WR_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [19:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [19:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,

    output logic [19:0] sram_addr,
    inout  logic [31:0] sram_data,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam int unsigned   CW      = 8;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          grant_data;   // 1 = current access belongs to the data port
    logic          drive_en;     // SRAM data bus driven by this block
    logic [31:0]   wdata_q;
    logic          win_data;     // arbitration result for this IDLE cycle

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic          prio_data;    // 1 = data port wins the next tie

    // Round-robin winner: pointer only matters when both ports request
    always_comb begin
        win_data = 1'b0;
        if (data_req && (!inst_req || prio_data)) begin
            win_data = 1'b1;
        end
    end
`else
    // Fixed priority: data port always wins a tie
    always_comb begin
        win_data = 1'b0;
        if (data_req) begin
            win_data = 1'b1;
        end
    end
`endif

    // Bus is only driven during the write states
    assign sram_data = drive_en ? wdata_q : 'z;

    // Access sequencer with registered SRAM pins, ready pulses and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            grant_data <= 1'b0;
            drive_en   <= 1'b0;
            wdata_q    <= '0;
            sram_addr  <= '0;
            sram_be_n  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            prio_data  <= 1'b1;
`endif
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        grant_data <= win_data;
                        wait_cnt   <= '0;
                        sram_ce_n  <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        prio_data  <= !win_data;
`endif
                        if (win_data) begin
                            sram_addr <= data_addr;
                            wdata_q   <= data_wdata;
                            if (data_we) begin
                                sram_be_n <= ~data_be;
                                drive_en  <= 1'b1;
                                state     <= WR_SETUP;
                            end else begin
                                sram_be_n <= '0;
                                sram_oe_n <= 1'b0;
                                state     <= READ;
                            end
                        end else begin
                            sram_addr <= inst_addr;
                            sram_be_n <= '0;
                            sram_oe_n <= 1'b0;
                            state     <= READ;
                        end
                    end
                end

                READ: begin
                    if (wait_cnt == RD_LAST) begin
                        if (grant_data) begin
                            data_rdata <= sram_data;
                            data_ready <= 1'b1;
                        end else begin
                            inst_rdata <= sram_data;
                            inst_ready <= 1'b1;
                        end
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_addr <= '0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= WR_PULSE;
                end

                WR_PULSE: begin
                    if (wait_cnt == WR_LAST) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                WR_HOLD: begin
                    sram_ce_n  <= 1'b1;
                    sram_be_n  <= '0;
                    sram_addr  <= '0;
                    drive_en   <= 1'b0;
                    data_ready <= 1'b1;
                    state      <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (RD_WAIT=0, WR_WAIT=1) with a
// behavioural asynchronous SRAM model. Expected round-robin behaviour is
// selected by SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_arbiter;

    localparam int unsigned RD_WAIT = 0;
    localparam int unsigned WR_WAIT = 1;
    localparam logic [31:0] PROBE   = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [19:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [19:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    logic [31:0] mem [0:255];
    logic        probe_en;
    logic        model_drive;

    int          checks = 0;
    int          errors = 0;
    logic        ptr_data;
    logic [31:0] exp_inst_rd;
    logic [31:0] exp_data_rd;

    sram_arbiter #(
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ready (inst_ready),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_be    (data_be),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ready (data_ready),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .sram_be_n  (sram_be_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM read path; PROBE value shows the bus is released
    assign model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_data   = model_drive ? mem[sram_addr[7:0]] : (probe_en ? PROBE : 'z);

    // SRAM write: byte lanes with be_n low are written while we_n is low
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port_data;
        logic        we;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic run_access(input vec_t v);
        int   lat;
        int   we_low;
        int   oe_low;
        logic seen;
        logic rdy;
        logic other;
        lat    = -1;
        we_low = 0;
        oe_low = 0;
        seen   = 1'b0;
        @(posedge clk); #1;
        if (v.port_data) begin
            data_req = 1'b1; data_we = v.we; data_be = v.be;
            data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            inst_req = 1'b1; inst_addr = v.addr;
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) begin
                oe_low++;
                check("rd_addr", {12'd0, sram_addr}, {12'd0, v.addr});
                check("rd_be_n", {28'd0, sram_be_n}, 32'd0);
            end
            if (!sram_ce_n && sram_oe_n) begin
                check("wr_bus", sram_data, v.wdata);
                check("wr_be_n", {28'd0, sram_be_n}, {28'd0, ~v.be});
                check("wr_addr", {12'd0, sram_addr}, {12'd0, v.addr});
            end
            rdy   = v.port_data ? data_ready : inst_ready;
            other = v.port_data ? inst_ready : data_ready;
            check("other_ready", {31'd0, other}, 32'd0);
            if (rdy) begin
                seen = 1'b1;
                lat  = c;
                if (!v.we) check("rdata", v.port_data ? data_rdata : inst_rdata, v.exp_rdata);
                if (v.port_data) data_req = 1'b0; else inst_req = 1'b0;
            end
        end
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("we_low_cycles", 32'(we_low), v.we ? 32'(WR_WAIT + 1) : 32'd0);
        check("oe_low_cycles", 32'(oe_low), v.we ? 32'd0 : 32'(RD_WAIT + 1));
        if (!v.we) begin
            if (v.port_data) exp_data_rd = v.exp_rdata; else exp_inst_rd = v.exp_rdata;
        end
        ptr_data = !v.port_data;
        @(negedge clk);
        check("inst_rdata_held", inst_rdata, exp_inst_rd);
        check("data_rdata_held", data_rdata, exp_data_rd);
    endtask

    // Both ports request reads in the same cycle
    task automatic contention(input logic [19:0] ia, input logic [19:0] da,
                              input logic [31:0] iexp, input logic [31:0] dexp);
        int   d_lat;
        int   i_lat;
        logic win_data;
        d_lat = -1;
        i_lat = -1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        win_data = ptr_data;
`else
        win_data = 1'b1;
`endif
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = ia;
        data_req = 1'b1; data_we = 1'b0; data_addr = da;
        for (int c = 0; c < 30 && (d_lat < 0 || i_lat < 0); c++) begin
            @(negedge clk);
            check("ready_overlap", {31'd0, data_ready & inst_ready}, 32'd0);
            if (data_ready) begin
                d_lat = c;
                check("cont_data_rdata", data_rdata, dexp);
                data_req = 1'b0;
            end
            if (inst_ready) begin
                i_lat = c;
                check("cont_inst_rdata", inst_rdata, iexp);
                inst_req = 1'b0;
            end
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        check("cont_data_lat", 32'(d_lat), win_data ? 32'd2 : 32'd5);
        check("cont_inst_lat", 32'(i_lat), win_data ? 32'd5 : 32'd2);
        exp_inst_rd = iexp;
        exp_data_rd = dexp;
        ptr_data    = win_data;
        @(negedge clk);
    endtask

    initial begin
        int   grants;
        int   last_c;
        int   oe_low;
        int   pulses;
        logic exp_win;
        logic found;
        logic gdata;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h1234_ABCD;
        mem[8'h20] = 32'h1122_3344;
        mem[8'h30] = 32'hCAFE_F00D;

        vecs[0] = '{1'b0, 1'b0, 4'b0000, 20'h00010, 32'h0, 32'h1234_ABCD, 2};
        vecs[1] = '{1'b1, 1'b1, 4'b0100, 20'h00020, 32'hAABB_CCDD, 32'h0, 5};
        vecs[2] = '{1'b1, 1'b0, 4'b0000, 20'h00020, 32'h0, 32'h11BB_3344, 2};
        vecs[3] = '{1'b1, 1'b1, 4'b0000, 20'h00030, 32'hFFFF_FFFF, 32'h0, 5};
        vecs[4] = '{1'b1, 1'b1, 4'b1111, 20'h00031, 32'h55AA_55AA, 32'h0, 5};
        vecs[5] = '{1'b0, 1'b0, 4'b0000, 20'h00031, 32'h0, 32'h55AA_55AA, 2};
        vecs[6] = '{1'b1, 1'b0, 4'b0000, 20'h00030, 32'h0, 32'hCAFE_F00D, 2};
        vecs[7] = '{1'b1, 1'b1, 4'b0011, 20'h00010, 32'h0000_9999, 32'h0, 5};
        vecs[8] = '{1'b0, 1'b0, 4'b0000, 20'h00010, 32'h0, 32'h1234_9999, 2};

        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
        probe_en = 1'b1;
        exp_inst_rd = '0;
        exp_data_rd = '0;
        ptr_data = 1'b1;

        // Reset state
        rst = 1'b1;
        #1;
        check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_be_n", {28'd0, sram_be_n}, 32'd0);
        check("rst_addr", {12'd0, sram_addr}, 32'd0);
        check("rst_bus_released", sram_data, PROBE);
        check("rst_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        probe_en = 1'b0;

        // Directed single transactions
        for (int i = 0; i < 9; i++) run_access(vecs[i]);
        check("mem_byte_write", mem[8'h20], 32'h11BB_3344);
        check("mem_be0_write", mem[8'h30], 32'hCAFE_F00D);

        // Simultaneous requests
        contention(20'h00031, 20'h00020, 32'h55AA_55AA, 32'h11BB_3344);

        // Both requesters held for four grants
        grants = 0;
        last_c = -1;
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 20'h00010;
        data_req = 1'b1; data_we = 1'b0; data_addr = 20'h00030;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            check("rr_overlap", {31'd0, data_ready & inst_ready}, 32'd0);
            if (data_ready || inst_ready) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                exp_win = ptr_data;
`else
                exp_win = 1'b1;
`endif
                gdata = data_ready;
                check("grant_order", {31'd0, gdata}, {31'd0, exp_win});
                check("grant_spacing", 32'(c - last_c), (last_c < 0) ? 32'd3 : 32'd3);
                if (gdata) check("rr_data_rdata", data_rdata, 32'hCAFE_F00D);
                else       check("rr_inst_rdata", inst_rdata, 32'h1234_9999);
                if (gdata) exp_data_rd = 32'hCAFE_F00D; else exp_inst_rd = 32'h1234_9999;
                ptr_data = !gdata;
                last_c = c;
                grants++;
            end
        end
        check("rr_grant_count", 32'(grants), 32'd4);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Request still high during DONE must not start a second access
        oe_low = 0;
        pulses = 0;
        found  = 1'b0;
        @(posedge clk); #1;
        data_req = 1'b1; data_we = 1'b0; data_addr = 20'h00031;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!sram_oe_n) oe_low++;
            if (data_ready) begin
                found = 1'b1;
                pulses++;
                check("held_rdata", data_rdata, 32'h55AA_55AA);
            end
        end
        @(posedge clk); #1;
        data_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!sram_oe_n) oe_low++;
            if (data_ready) pulses++;
        end
        check("held_oe_cycles", 32'(oe_low), 32'(RD_WAIT + 1));
        check("held_ready_pulses", 32'(pulses), 32'd1);
        exp_data_rd = 32'h55AA_55AA;
        ptr_data = 1'b0;

        // Reset asserted in the middle of the write pulse
        found = 1'b0;
        @(posedge clk); #1;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b1111;
        data_addr = 20'h00040; data_wdata = 32'h0BAD_F00D;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!sram_we_n) found = 1'b1;
        end
        check("reached_wr_pulse", {31'd0, found}, 32'd1);
        probe_en = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("midrst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("midrst_bus_released", sram_data, PROBE);
        check("midrst_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        data_req = 1'b0;
        data_we  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        check("postrst_inst_rdata", inst_rdata, 32'd0);
        check("postrst_data_rdata", data_rdata, 32'd0);
        check("postrst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        probe_en = 1'b0;
        exp_inst_rd = '0;
        exp_data_rd = '0;
        ptr_data = 1'b1;
        run_access(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
